// File: rtl/seq_chain_detect.sv
// Ordered event-chain detector: ev[0]..ev[N_STEPS-1] must fire in order with at most MAX_GAP idle cycles between steps.
// Optional SEQ_CHAIN_RESTART_EN: an abort caused by ev[0] re-arms at step 1 instead of dropping to idle.
module seq_chain_detect #(
  parameter int unsigned N_STEPS = 3,
  parameter int unsigned MAX_GAP = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_STEPS-1:0]           ev,
  input  logic                         clr,
  output logic                         match,
  output logic                         fail,
  output logic [$clog2(N_STEPS+1)-1:0] step,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int unsigned SW = $clog2(N_STEPS+1);
  localparam logic [N_STEPS-1:0] FIRST   = N_STEPS'(1);
  localparam logic [SW-1:0]      LAST    = SW'(N_STEPS-1);
  localparam logic [7:0]         GAP_MAX = 8'(MAX_GAP);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   step_n;
  logic [7:0]      gap, gap_n;
  logic            match_n, fail_n;
  logic [N_STEPS-1:0] expect_ev;

  assign expect_ev = FIRST << step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      gap   <= '0;
      match <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      gap   <= gap_n;
      match <= match_n;
      fail  <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    gap_n   = gap;
    match_n = 1'b0;
    fail_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ev == FIRST) begin
          state_n = ARMED;
          step_n  = SW'(1);
          gap_n   = '0;
        end
      end
      ARMED: begin
        if (ev == expect_ev) begin
          gap_n = '0;
          if (step == LAST) begin
            match_n = 1'b1;
            state_n = IDLE;
            step_n  = '0;
          end else begin
            step_n = step + SW'(1);
          end
        end else if (ev == '0 && gap != GAP_MAX) begin
          gap_n = gap + 8'd1;
        end else begin
          // Gap overrun, wrong step or multiple steps: abort the chain.
          fail_n  = 1'b1;
          state_n = IDLE;
          step_n  = '0;
          gap_n   = '0;
`ifdef SEQ_CHAIN_RESTART_EN
          if (ev == FIRST) begin
            state_n = ARMED;
            step_n  = SW'(1);
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
        step_n  = '0;
        gap_n   = '0;
      end
    endcase
  end

  // Counters follow the next-state decision so they update together with the pulses; clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      err_cnt   <= '0;
    end else if (clr) begin
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (match_n && match_cnt != '1)
        match_cnt <= match_cnt + CNT_W'(1);
      if (fail_n && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_chain_detect.sv
// Directed bench for seq_chain_detect: three instances (default, MAX_GAP=2, CNT_W=2) driven independently.
module tb_seq_chain_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ev_a = '0, ev_b = '0, ev_c = '0;
  logic       clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

  logic       match_a, fail_a, match_b, fail_b, match_c, fail_c;
  logic [1:0] step_a, step_b, step_c;
  logic [7:0] mcnt_a, ecnt_a, mcnt_b, ecnt_b;
  logic [1:0] mcnt_c, ecnt_c;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  seq_chain_detect #(.N_STEPS(3), .MAX_GAP(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ev(ev_a), .clr(clr_a), .match(match_a), .fail(fail_a),
    .step(step_a), .match_cnt(mcnt_a), .err_cnt(ecnt_a));

  seq_chain_detect #(.N_STEPS(3), .MAX_GAP(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ev(ev_b), .clr(clr_b), .match(match_b), .fail(fail_b),
    .step(step_b), .match_cnt(mcnt_b), .err_cnt(ecnt_b));

  seq_chain_detect #(.N_STEPS(3), .MAX_GAP(0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .ev(ev_c), .clr(clr_c), .match(match_c), .fail(fail_c),
    .step(step_c), .match_cnt(mcnt_c), .err_cnt(ecnt_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_a_step", 32'(step_a), 0);
    chk("rst_a_match", 32'(match_a), 0);
    chk("rst_a_fail", 32'(fail_a), 0);
    chk("rst_a_mcnt", 32'(mcnt_a), 0);
    chk("rst_b_ecnt", 32'(ecnt_b), 0);
    chk("rst_c_mcnt", 32'(mcnt_c), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic consecutive match
    ev_a = 3'b001; tick();
    chk("m1_step1", 32'(step_a), 1);
    ev_a = 3'b010; tick();
    chk("m1_step2", 32'(step_a), 2);
    chk("m1_nomatch_yet", 32'(match_a), 0);
    ev_a = 3'b100; tick();
    chk("m1_match", 32'(match_a), 1);
    chk("m1_fail0", 32'(fail_a), 0);
    chk("m1_mcnt", 32'(mcnt_a), 1);
    chk("m1_step0", 32'(step_a), 0);
    ev_a = 3'b000; tick();
    chk("m1_pulse_end", 32'(match_a), 0);

    // Gap of one with MAX_GAP=0
    ev_a = 3'b001; tick();
    ev_a = 3'b000; tick();
    chk("g0_fail", 32'(fail_a), 1);
    chk("g0_ecnt", 32'(ecnt_a), 1);
    chk("g0_step", 32'(step_a), 0);
    ev_a = 3'b010; tick();
    chk("g0_fail_end", 32'(fail_a), 0);
    chk("g0_nomatch", 32'(match_a), 0);
    chk("g0_idle", 32'(step_a), 0);
    ev_a = 3'b000; tick();

    // Repeated ev[0] while armed
    ev_a = 3'b001; tick();
    ev_a = 3'b001; tick();
    chk("rs_fail", 32'(fail_a), 1);
    chk("rs_ecnt", 32'(ecnt_a), 2);
`ifdef SEQ_CHAIN_RESTART_EN
    chk("rs_step", 32'(step_a), 1);
    ev_a = 3'b010; tick();
    chk("rs_step2", 32'(step_a), 2);
    ev_a = 3'b100; tick();
    chk("rs_match", 32'(match_a), 1);
    chk("rs_mcnt", 32'(mcnt_a), 2);
`else
    chk("rs_step", 32'(step_a), 0);
    ev_a = 3'b010; tick();
    chk("rs_step2", 32'(step_a), 0);
    ev_a = 3'b100; tick();
    chk("rs_match", 32'(match_a), 0);
    chk("rs_mcnt", 32'(mcnt_a), 1);
`endif
    ev_a = 3'b000; tick();

    // Multiple bits while armed
    ev_a = 3'b001; tick();
    ev_a = 3'b011; tick();
    chk("mb_fail", 32'(fail_a), 1);
    chk("mb_match0", 32'(match_a), 0);
    chk("mb_ecnt", 32'(ecnt_a), 3);
    chk("mb_step", 32'(step_a), 0);
    ev_a = 3'b000; tick();

    // Wrong order ignored in idle
    ev_a = 3'b010; tick();
    chk("idle_ignore", 32'(step_a), 0);
    chk("idle_nofail", 32'(fail_a), 0);
    ev_a = 3'b000; tick();

    // Reset mid-sequence
    ev_a = 3'b001; tick();
    ev_a = 3'b010; tick();
    chk("rm_step2", 32'(step_a), 2);
    ev_a = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("rm_step", 32'(step_a), 0);
    chk("rm_mcnt", 32'(mcnt_a), 0);
    chk("rm_ecnt", 32'(ecnt_a), 0);
    chk("rm_fail", 32'(fail_a), 0);
    tick();
    chk("rm_fail_hold", 32'(fail_a), 0);
    rst_n = 1'b1;
    ev_a = 3'b100; tick();
    chk("rm_nomatch", 32'(match_a), 0);
    chk("rm_nofail", 32'(fail_a), 0);
    chk("rm_idle", 32'(step_a), 0);
    ev_a = 3'b000; tick();

    // MAX_GAP=2: two idle cycles tolerated
    ev_b = 3'b001; tick();
    ev_b = 3'b000; tick();
    ev_b = 3'b000; tick();
    chk("g2_still_armed", 32'(step_b), 1);
    chk("g2_nofail", 32'(fail_b), 0);
    ev_b = 3'b010; tick();
    ev_b = 3'b000; tick();
    ev_b = 3'b100; tick();
    chk("g2_match", 32'(match_b), 1);
    chk("g2_mcnt", 32'(mcnt_b), 1);
    // three idle cycles exceed the gap
    ev_b = 3'b001; tick();
    ev_b = 3'b000; tick();
    ev_b = 3'b000; tick();
    chk("g3_notyet", 32'(fail_b), 0);
    ev_b = 3'b000; tick();
    chk("g3_fail", 32'(fail_b), 1);
    chk("g3_ecnt", 32'(ecnt_b), 1);
    chk("g3_step", 32'(step_b), 0);
    ev_b = 3'b010; tick();
    ev_b = 3'b100; tick();
    chk("g3_nomatch", 32'(match_b), 0);
    ev_b = 3'b000; tick();

    // CNT_W=2 saturation, then clr coincident with a match
    for (int i = 0; i < 4; i++) begin
      ev_c = 3'b001; tick();
      ev_c = 3'b010; tick();
      ev_c = 3'b100; tick();
      chk("sat_mcnt", 32'(mcnt_c), (i < 3) ? i + 1 : 3);
    end
    ev_c = 3'b001; tick();
    clr_c = 1'b1;
    ev_c = 3'b010; tick();
    chk("clr_fsm_kept", 32'(step_c), 2);
    chk("clr_zero", 32'(mcnt_c), 0);
    ev_c = 3'b100; tick();
    chk("clr_match", 32'(match_c), 1);
    chk("clr_wins", 32'(mcnt_c), 0);
    clr_c = 1'b0;
    ev_c = 3'b000; tick();
    chk("clr_released", 32'(mcnt_c), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
